// File: rtl/psum_accum_binarize.sv
// psum_accum_binarize: per-channel psum accumulation over passes, then threshold + flip to binary activations.
// Define PSUM_ACC_SAT_EN for saturating accumulation; otherwise accumulators wrap.
module psum_accum_binarize #(
  parameter int WIDTH    = 14,
  parameter int O_CH     = 64,
  parameter int ACC_W    = 20,
  parameter int MAX_PASS = 64,
  parameter int PCW      = $clog2(MAX_PASS + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  psum_valid_in,
  output logic                  psum_ready_out,
  input  logic [WIDTH*O_CH-1:0] psum_in,
  input  logic                  last_in,
  input  logic [ACC_W*O_CH-1:0] thresh_in,
  input  logic [O_CH-1:0]       flip_in,
  output logic                  act_valid_out,
  input  logic                  act_ready_in,
  output logic [O_CH-1:0]       act_out,
  output logic [PCW-1:0]        pass_cnt_out,
  output logic                  overflow_out
);
  typedef enum logic [1:0] {ACCUM, COMPARE, OUTPUT} state_t;
  state_t state, state_nx;
  logic accept, done;
  logic [PCW-1:0] cnt_nx;
  logic signed [ACC_W-1:0] acc [O_CH];
  logic signed [ACC_W-1:0] acc_nx [O_CH];
  logic [O_CH-1:0] cmp;
  assign psum_ready_out = state == ACCUM;
  assign act_valid_out  = state == OUTPUT;
  assign accept = psum_valid_in && psum_ready_out;
  assign cnt_nx = pass_cnt_out + PCW'(1);
  assign done   = last_in || cnt_nx == PCW'(MAX_PASS);
  for (genvar g = 0; g < O_CH; g++) begin : g_lane
    logic signed [ACC_W-1:0] base, lane_x, thr;
    // a new tile starts from zero instead of clearing accumulators in COMPARE
    assign base   = pass_cnt_out == '0 ? '0 : acc[g];
    assign lane_x = ACC_W'($signed(psum_in[WIDTH*(O_CH-g)-1 -: WIDTH]));
`ifdef PSUM_ACC_SAT_EN
    logic signed [ACC_W:0] wide;
    assign wide = {base[ACC_W-1], base} + {lane_x[ACC_W-1], lane_x};
    assign acc_nx[g] = wide[ACC_W] == wide[ACC_W-1] ? wide[ACC_W-1:0]
                                                    : {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
`else
    assign acc_nx[g] = base + lane_x;
`endif
    assign thr = $signed(thresh_in[ACC_W*(O_CH-g)-1 -: ACC_W]);
    assign cmp[O_CH-1-g] = (acc[g] >= thr) ^ flip_in[g];
  end
  always_comb begin
    state_nx = state;
    if (state == ACCUM && accept && done) state_nx = COMPARE;
    else if (state == COMPARE) state_nx = OUTPUT;
    else if (state == OUTPUT && act_ready_in) state_nx = ACCUM;
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state        <= ACCUM;
      pass_cnt_out <= '0;
      overflow_out <= 1'b0;
      act_out      <= '0;
      for (int k = 0; k < O_CH; k++) acc[k] <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc          <= acc_nx;
        pass_cnt_out <= cnt_nx;
        if (!last_in && cnt_nx == PCW'(MAX_PASS)) overflow_out <= 1'b1;
      end
      if (state == COMPARE) begin
        act_out      <= cmp;
        pass_cnt_out <= '0;
      end
    end
endmodule

// File: tb/tb_psum_accum_binarize.sv
// tb_psum_accum_binarize: directed checks of accumulate/threshold/handshake, plus wide-accumulate overflow on a MAX_PASS=8 instance.
module tb_psum_accum_binarize;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic psum_valid = 0, psum_ready, last = 0, act_valid, act_ready = 0, overflow;
  logic [55:0] psum = '0;
  logic [63:0] thresh = '0;
  logic [3:0] flip = '0, act;
  logic [2:0] pass_cnt;
  logic b_valid = 0, b_ready, b_act_valid, b_act_ready = 0, b_act, b_overflow;
  logic [13:0] b_psum = 14'd8191;
  logic [3:0] b_cnt;
  int errors = 0, checks = 0;

  psum_accum_binarize #(.WIDTH(14), .O_CH(4), .ACC_W(16), .MAX_PASS(4)) u_dut (
    .clk_in(clk), .rst_in(rst_n), .psum_valid_in(psum_valid), .psum_ready_out(psum_ready),
    .psum_in(psum), .last_in(last), .thresh_in(thresh), .flip_in(flip),
    .act_valid_out(act_valid), .act_ready_in(act_ready), .act_out(act),
    .pass_cnt_out(pass_cnt), .overflow_out(overflow));

  psum_accum_binarize #(.WIDTH(14), .O_CH(1), .ACC_W(16), .MAX_PASS(8)) u_dut8 (
    .clk_in(clk), .rst_in(rst_n), .psum_valid_in(b_valid), .psum_ready_out(b_ready),
    .psum_in(b_psum), .last_in(1'b0), .thresh_in(16'd0), .flip_in(1'b0),
    .act_valid_out(b_act_valid), .act_ready_in(b_act_ready), .act_out(b_act),
    .pass_cnt_out(b_cnt), .overflow_out(b_overflow));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] pk(input int a, input int b, input int c, input int d);
    return {14'(a), 14'(b), 14'(c), 14'(d)};
  endfunction

  function automatic logic [63:0] tk(input int a, input int b, input int c, input int d);
    return {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  function automatic logic [3:0] model(input logic [55:0] p, input logic [63:0] t, input logic [3:0] f);
    logic [3:0] r;
    logic signed [15:0] s, th;
    for (int k = 0; k < 4; k++) begin
      s  = 16'($signed(p[14*(4-k)-1 -: 14]));
      th = $signed(t[16*(4-k)-1 -: 16]);
      r[3-k] = (s >= th) ^ f[k];
    end
    return r;
  endfunction

  task automatic send(input logic [55:0] p, input logic l);
    @(negedge clk);
    check("psum_ready", psum_ready, 1);
    psum = p; last = l; psum_valid = 1;
    @(negedge clk);
    psum_valid = 0; last = 0;
  endtask

  task automatic take();
    act_ready = 1;
    @(negedge clk);
    act_ready = 0;
    check("act_release", act_valid, 0);
  endtask

  task automatic wait_act();
    int n = 0;
    while (!act_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("act_valid_wait", act_valid, 1);
  endtask

  initial begin
    #12;
    check("rst_act_valid", act_valid, 0);
    check("rst_act", act, 0);
    check("rst_cnt", pass_cnt, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ready", psum_ready, 1);
    @(negedge clk); rst_n = 1;
    // tile of three beats, sums {15,-9,0,300}
    thresh = tk(10, -8, 0, 301);
    send(pk(5, -3, 0, 100), 0);
    send(pk(5, -3, 0, 100), 0);
    check("cnt_mid", pass_cnt, 2);
    send(pk(5, -3, 0, 100), 1);
    check("lat_compare", act_valid, 0);
    @(negedge clk);
    check("lat_output", act_valid, 1);
    check("t1_act", act, 4'b1010);
    check("t1_cnt", pass_cnt, 0);
    take();
    // flipped, consumer stalls five cycles
    flip = 4'b1111;
    repeat (3) send(pk(5, -3, 0, 100), 0);
    check("t2_no_cmp_yet", act_valid, 0);
    send(pk(0, 0, 0, 0), 1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", act_valid, 1);
      check("t2_hold_act", act, 4'b0101);
      check("t2_hold_ready", psum_ready, 0);
      @(negedge clk);
    end
    take();
    // forced end at MAX_PASS
    flip = 4'b0000;
    thresh = tk(4, 5, -1, 3);
    repeat (4) send(pk(1, 1, 1, 1), 0);
    check("t3_ovf", overflow, 1);
    check("t3_compare", act_valid, 0);
    @(negedge clk);
    check("t3_act", act, 4'b1011);
    take();
    send(pk(1, 1, 1, 1), 1);
    wait_act();
    check("t3_next_act", act, 4'b0010);
    check("t3_ovf_sticky", overflow, 1);
    take();
    // async reset mid-tile
    thresh = tk(8, 0, -1, 8);
    send(pk(5, -3, 0, 100), 0);
    send(pk(5, -3, 0, 100), 0);
    #2 rst_n = 0;
    #1;
    check("t5_cnt", pass_cnt, 0);
    check("t5_ovf", overflow, 0);
    check("t5_act", act, 0);
    check("t5_valid", act_valid, 0);
    @(negedge clk); rst_n = 1;
    send(pk(7, 7, 7, 7), 1);
    wait_act();
    check("t5_fresh", act, 4'b0110);
    take();
    // back-to-back single-beat tiles with random gaps
    thresh = tk(0, 100, -100, 0);
    flip = 4'b1001;
    for (int t = 0; t < 8; t++) begin
      logic [55:0] p;
      p = {14'($urandom), 14'($urandom), 14'($urandom), 14'($urandom)};
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(p, 1);
      wait_act();
      check("t6_act", act, model(p, thresh, flip));
      take();
    end
    // 8 x 8191 into a 16-bit accumulator
    @(negedge clk); b_valid = 1;
    repeat (8) @(negedge clk);
    b_valid = 0;
    check("t4_ovf", b_overflow, 1);
    @(negedge clk);
    check("t4_valid", b_act_valid, 1);
`ifdef PSUM_ACC_SAT_EN
    check("t4_act", b_act, 1);
`else
    check("t4_act", b_act, 0);
`endif
    b_act_ready = 1;
    @(negedge clk);
    b_act_ready = 0;
    check("t4_release", b_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
